// File: rtl/rgb_pwm_fader_pkg.sv
// Shared types and widths for the RGB PWM fader: duty width, FSM state
// encoding and the packed colour triple.
package rgb_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FADE
  } state_t;

  typedef struct packed {
    logic [DUTY_W-1:0] r;
    logic [DUTY_W-1:0] g;
    logic [DUTY_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Target-colour handshake between a colour source and the fader.
interface rgb_pwm_fader_if;
  import rgb_pkg::*;

  logic [DUTY_W-1:0] tgt_r;
  logic [DUTY_W-1:0] tgt_g;
  logic [DUTY_W-1:0] tgt_b;
  logic              tgt_fade;
  logic              tgt_valid;
  logic              tgt_ready;

  modport master (
    output tgt_r, tgt_g, tgt_b, tgt_fade, tgt_valid,
    input  tgt_ready
  );

  modport slave (
    input  tgt_r, tgt_g, tgt_b, tgt_fade, tgt_valid,
    output tgt_ready
  );

endinterface

// File: rtl/rgb_pwm_fader_channel.sv
// One PWM colour channel: owns the applied duty and the registered compare.
// The duty only moves on a period boundary, so no partial periods appear.
module rgb_pwm_channel
  import rgb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] pwm_cnt,
  input  logic              wrap,
  input  logic              step_en,
  input  logic              load_en,
  input  logic [DUTY_W-1:0] tgt,
  output logic              pwm,
  output logic [DUTY_W-1:0] duty,
  output logic              done,
  output logic              near
);

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              pwm_q, pwm_d;

  always_comb begin
    duty_d = duty_q;
    pwm_d  = (pwm_cnt < duty_q);
    if (wrap && load_en) begin
      duty_d = tgt;
    end else if (wrap && step_en) begin
      // Saturating single-LSB move: stops exactly on the target.
      if (duty_q < tgt) begin
        duty_d = duty_q + DUTY_W'(1);
      end else if (duty_q > tgt) begin
        duty_d = duty_q - DUTY_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm  = pwm_q;
  assign duty = duty_q;
  assign done = (duty_q == tgt);
  // One LSB away: the next step will land on the target.
  assign near = (duty_q < tgt) ? ((tgt - duty_q) == DUTY_W'(1))
                               : ((duty_q - tgt) == DUTY_W'(1));

endmodule

// File: rtl/rgb_pwm_fader.sv
// Three-channel PWM generator with wrap-aligned jump or one-LSB-per-step
// fading toward a target colour accepted over a valid/ready handshake.
module rgb_pwm_fader
  import rgb_pkg::*;
#(
  parameter int PRESCALE     = 4,
  parameter int STEP_PERIODS = 2
) (
  input  logic              hw_clk,
  input  logic              rst,
  rgb_pwm_fader_if.slave    tgt,
  output logic              pwm_r,
  output logic              pwm_g,
  output logic              pwm_b,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic              busy
);

  logic [15:0]       pre_cnt_q, pre_cnt_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0]        step_cnt_q, step_cnt_d;
  state_t            state_q, state_d;
  rgb_t              tgt_q, tgt_d;
  logic              fade_q, fade_d;

  logic       tick, wrap, step_en, load_en;
  logic [2:0] done, near;
  logic       all_done, last_step;

  assign tick      = (pre_cnt_q == 16'(PRESCALE - 1));
  assign wrap      = tick && (pwm_cnt_q == '1);
  assign all_done  = &done;
  assign last_step = &(done | near);

  always_comb begin
    pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
    pwm_cnt_d = tick ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    fade_d     = fade_q;
    step_cnt_d = step_cnt_q;
    step_en    = 1'b0;
    load_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tgt.tgt_valid) begin
          tgt_d.r = tgt.tgt_r;
          tgt_d.g = tgt.tgt_g;
          tgt_d.b = tgt.tgt_b;
          fade_d  = tgt.tgt_fade;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (wrap) begin
          if (!fade_q) begin
            load_en = 1'b1;
            state_d = ST_IDLE;
          end else if (all_done) begin
            state_d = ST_IDLE;
          end else begin
            step_cnt_d = 8'd0;
            state_d    = ST_FADE;
          end
        end
      end
      ST_FADE: begin
        if (wrap) begin
          if (step_cnt_q == 8'(STEP_PERIODS - 1)) begin
            step_cnt_d = 8'd0;
            step_en    = 1'b1;
            // Leave in the step cycle so ready rises right after the last move.
            if (last_step) begin
              state_d = ST_IDLE;
            end
          end else begin
            step_cnt_d = step_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hw_clk) begin
    if (rst) begin
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      state_q    <= ST_IDLE;
      tgt_q      <= '0;
      fade_q     <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      fade_q     <= fade_d;
    end
  end

  assign tgt.tgt_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);

  rgb_pwm_channel u_ch_r (
    .clk(hw_clk), .rst(rst), .pwm_cnt(pwm_cnt_q), .wrap(wrap),
    .step_en(step_en), .load_en(load_en), .tgt(tgt_q.r),
    .pwm(pwm_r), .duty(duty_r), .done(done[0]), .near(near[0])
  );

  rgb_pwm_channel u_ch_g (
    .clk(hw_clk), .rst(rst), .pwm_cnt(pwm_cnt_q), .wrap(wrap),
    .step_en(step_en), .load_en(load_en), .tgt(tgt_q.g),
    .pwm(pwm_g), .duty(duty_g), .done(done[1]), .near(near[1])
  );

  rgb_pwm_channel u_ch_b (
    .clk(hw_clk), .rst(rst), .pwm_cnt(pwm_cnt_q), .wrap(wrap),
    .step_en(step_en), .load_en(load_en), .tgt(tgt_q.b),
    .pwm(pwm_b), .duty(duty_b), .done(done[2]), .near(near[2])
  );

endmodule

// File: doc/rgb_pwm_fader.md
# rgb_pwm_fader

Three-channel PWM generator with colour fading, sitting directly upstream of the `SB_RGBA_DRV` instance on the iCE40UP5K. It accepts target RGB duty values over a valid/ready handshake and ramps each channel's current duty toward its target, one LSB per step. It drives the `RGB0PWM`/`RGB1PWM`/`RGB2PWM` inputs with glitch-free, period-aligned PWM. It is clocked from the `SB_HFOSC` output.

## Interface
- `PRESCALE`, default 4: clock cycles per PWM counter increment; legal range 1..65535.
- `STEP_PERIODS`, default 2: complete PWM periods per fade step; legal range 1..255.
- `hw_clk`  in  1  system clock, `int_osc` from `SB_HFOSC` at the top level.
- `rst`  in  1  synchronous reset, active-high.
- `tgt_r`, `tgt_g`, `tgt_b`  in  8 each  target duty per channel; 0 = off, 255 = 255/256 on.
- `tgt_fade`  in  1  sampled on accept; 1 = ramp to the target, 0 = jump to the target.
- `tgt_valid`  in  1  target word is valid.
- `tgt_ready`  out  1  block can accept a target; reset value 1.
- `pwm_r`, `pwm_g`, `pwm_b`  out  1 each  PWM to `RGB0PWM`/`RGB1PWM`/`RGB2PWM`; reset value 0.
- `duty_r`, `duty_g`, `duty_b`  out  8 each  current applied duty; reset value 0.
- `busy`  out  1  high while a target is pending or fading; reset value 0.

## Operation
- **Prescaler.** `pre_cnt` counts 0..PRESCALE-1. The `tick` signal asserts on the cycle where `pre_cnt == PRESCALE-1`.
- **PWM counter.** `pwm_cnt` is 8 bits and advances on each `tick`, wrapping from 255 to 0.
  - `wrap` = `tick && pwm_cnt == 255`. This marks the period boundary.
- **PWM outputs.** Registered each cycle: `pwm_x <= (pwm_cnt < duty_x)`.
  - Duty 0 never drives high.
  - Duty 255 drives low for exactly one count per period.
- **Duty update rule.** `duty_x` changes only on `wrap`. No partial periods are produced.
- **FSM states.**
  - IDLE: `tgt_ready`=1, `busy`=0.
  - LOAD: `tgt_ready`=0, `busy`=1. Waits for the next `wrap`.
  - FADE: `tgt_ready`=0, `busy`=1.
- **IDLE → LOAD.** Taken on accept (`tgt_valid && tgt_ready`). The block latches `tgt_*` and `tgt_fade`.
- **LOAD → IDLE (jump).** If `tgt_fade`=0, then on the next `wrap` set `duty_x <= tgt_x` and go to IDLE.
- **LOAD → FADE.** If `tgt_fade`=1, go to FADE without changing duty. The step counter `step_cnt` is cleared.
- **FADE.** On each `wrap`, `step_cnt` increments.
  - When `step_cnt == STEP_PERIODS-1`, the counter clears and each channel with `duty_x != tgt_x` moves one LSB toward its target.
  - The move is ±1. It never overshoots, and there is no wrap-around between 0 and 255.
  - When all three channels equal their targets after a step, go to IDLE in the same cycle.
- **Target already equal.** A target equal to the current duty still goes through LOAD. It returns to IDLE at the next `wrap` with no duty change.
- **Fade duration.** A channel needs |target − current| steps. The fade ends when the largest channel delta is reached. Channels finish independently.
- **Handshake rules.**
  - `tgt_*` is ignored when `tgt_ready`=0.
  - A source holding `tgt_valid` in IDLE is accepted in the first IDLE cycle.
  - Accepting a target means `tgt_ready` deasserts on the following cycle.
- **Reset.** A synchronous reset, including one asserted mid-fade, clears everything at the next edge: all counters, duties and outputs go to 0, the FSM goes to IDLE, and any pending target is discarded.

## Timing
- PWM period = 256·PRESCALE cycles.
- `pwm_x` lags the compare by 1 cycle.
- Accept to first duty change: at most 256·PRESCALE cycles, and at least 1 cycle, since the change lands on the next `wrap`.
- Fade step interval = STEP_PERIODS·256·PRESCALE cycles.
- `tgt_ready` rises in the cycle after the final `wrap`-aligned duty update.
- High time per period = duty_x·PRESCALE cycles, exact.

## Structure
- **Package `rgb_pkg`.** Holds `DUTY_W`=8, the FSM state enum (`ST_IDLE`, `ST_LOAD`, `ST_FADE`), and the `rgb_t` struct holding the r/g/b 8-bit fields.
- **Sub-module `rgb_pwm_channel`.** Instantiated three times. Inputs are the shared `pwm_cnt`, `wrap`, `step_en`, `load_en`, and the target. It owns `duty_x` and the `pwm_x` compare register. Its `done` output is `duty_x == tgt_x`.
- **Top level.** Holds the prescaler, the PWM counter, the step counter and the FSM.

## Test plan
- **Reset values.** Reset for 3 cycles. Then `pwm_*`=0, `duty_*`=0, `tgt_ready`=1, `busy`=0. Outputs stay 0 for 2 full periods.
- **Jump.** PRESCALE=1. Jump to (128,0,255). `duty_*` updates exactly on `wrap`. Per 256-cycle period, `pwm_r` is high 128 cycles, `pwm_g` 0 cycles, `pwm_b` 255 cycles.
- **Fade up.** STEP_PERIODS=1. From (0,0,0), fade to (3,10,0). `duty_r` reaches 3 after 3 periods and holds. `duty_g` reaches 10 after 10 periods. `busy` falls and `tgt_ready` rises at period 10.
- **Fade down.** Fade down from 255 to 250 with STEP_PERIODS=2. The duty decrements every 512·PRESCALE cycles. It ends at 250 with no underflow or overshoot.
- **Backpressure.** Hold `tgt_valid`=1 with changing data during a FADE. The data is ignored until IDLE. The word presented in the first IDLE cycle is accepted.
- **Mid-fade reset.** Assert `rst` mid-fade at duty 5 toward 20. Next cycle: all duties 0, FSM IDLE, `tgt_ready`=1. A new target is accepted immediately.
